// File: rtl/excp_ctrl.sv
// excp_ctrl: write-back exception/interrupt/ertn commit sequencer.
// Commits one event, drains the pipeline, then hands a redirect to fetch.
module excp_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic        ws_ex,
  input  logic [5:0]  ws_ecode,
  input  logic [8:0]  ws_esubcode,
  input  logic        ws_ertn,
  input  logic        has_int,
  input  logic [31:0] csr_excp_pc,
  input  logic [31:0] csr_ertn_pc,
  input  logic        redirect_ready,
  output logic        ws_allowin,
  output logic        ws_cancel,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic        ertn_flush,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] ex_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    DRAIN,
    REDIRECT
  } state_t;

  localparam int LD = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam logic [3:0] LOAD = LD[3:0];

  state_t      state_q;
  logic        ertn_q;
  logic [3:0]  cnt_q;
  logic [31:0] pc_q;
  logic [5:0]  ecode_q;
  logic [8:0]  esub_q;
  logic [31:0] ex_cnt_q;

  logic idle;
  logic ex_ev;
  logic ertn_ev;

  // Event detection; interrupt beats exception beats ertn.
  always_comb begin
    idle    = (state_q == IDLE);
    ex_ev   = idle & ws_valid & (has_int | ws_ex);
    ertn_ev = idle & ws_valid & ws_ertn & ~has_int & ~ws_ex;
  end

  // Sequencer: commit, drain, redirect handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ertn_q   <= 1'b0;
      cnt_q    <= 4'd0;
      pc_q     <= 32'd0;
      ecode_q  <= 6'd0;
      esub_q   <= 9'd0;
      ex_cnt_q <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ex_ev) begin
            state_q <= COMMIT;
            ertn_q  <= 1'b0;
            pc_q    <= ws_pc;
            ecode_q <= has_int ? 6'd0 : ws_ecode;
            esub_q  <= has_int ? 9'd0 : ws_esubcode;
          end else if (ertn_ev) begin
            state_q <= COMMIT;
            ertn_q  <= 1'b1;
            pc_q    <= ws_pc;
            ecode_q <= ws_ecode;
            esub_q  <= ws_esubcode;
          end
        end
        COMMIT: begin
          if (!ertn_q) ex_cnt_q <= ex_cnt_q + 32'd1;
          if (FLUSH_CYCLES == 0) begin
            state_q <= REDIRECT;
          end else begin
            state_q <= DRAIN;
            cnt_q   <= LOAD;
          end
        end
        DRAIN: begin
          if (cnt_q == 4'd0) state_q <= REDIRECT;
          else cnt_q <= cnt_q - 4'd1;
        end
        REDIRECT: begin
          if (redirect_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    ws_allowin     = idle;
    ws_cancel      = ex_ev;
    wb_ex          = (state_q == COMMIT) & ~ertn_q;
    ertn_flush     = (state_q == COMMIT) & ertn_q;
    flush          = ~idle;
    redirect_valid = (state_q == REDIRECT);
    redirect_pc    = ertn_q ? csr_ertn_pc : csr_excp_pc;
    wb_pc          = pc_q;
    wb_ecode       = ecode_q;
    wb_esubcode    = esub_q;
    ex_cnt         = ex_cnt_q;
  end

endmodule

// File: tb/tb_excp_ctrl.sv
// tb_excp_ctrl: directed checks of excp_ctrl.
// dut0 uses a 2-cycle drain, dut1 a zero-cycle drain.
module tb_excp_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic        ws_ex;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic        ws_ertn;
  logic        has_int;
  logic [31:0] csr_excp_pc;
  logic [31:0] csr_ertn_pc;
  logic        redirect_ready;

  logic        a_allowin, a_cancel, a_wb_ex, a_ertn, a_flush, a_rv;
  logic [5:0]  a_ecode;
  logic [8:0]  a_esub;
  logic [31:0] a_pc, a_rpc, a_cnt;
  logic        b_allowin, b_cancel, b_wb_ex, b_ertn, b_flush, b_rv;
  logic [5:0]  b_ecode;
  logic [8:0]  b_esub;
  logic [31:0] b_pc, b_rpc, b_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  excp_ctrl #(.FLUSH_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_pc(ws_pc),
    .ws_ex(ws_ex), .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode),
    .ws_ertn(ws_ertn), .has_int(has_int), .csr_excp_pc(csr_excp_pc),
    .csr_ertn_pc(csr_ertn_pc), .redirect_ready(redirect_ready),
    .ws_allowin(a_allowin), .ws_cancel(a_cancel), .wb_ex(a_wb_ex),
    .wb_ecode(a_ecode), .wb_esubcode(a_esub), .wb_pc(a_pc),
    .ertn_flush(a_ertn), .flush(a_flush), .redirect_valid(a_rv),
    .redirect_pc(a_rpc), .ex_cnt(a_cnt)
  );

  excp_ctrl #(.FLUSH_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .ws_valid(ws_valid), .ws_pc(ws_pc),
    .ws_ex(ws_ex), .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode),
    .ws_ertn(ws_ertn), .has_int(has_int), .csr_excp_pc(csr_excp_pc),
    .csr_ertn_pc(csr_ertn_pc), .redirect_ready(redirect_ready),
    .ws_allowin(b_allowin), .ws_cancel(b_cancel), .wb_ex(b_wb_ex),
    .wb_ecode(b_ecode), .wb_esubcode(b_esub), .wb_pc(b_pc),
    .ertn_flush(b_ertn), .flush(b_flush), .redirect_valid(b_rv),
    .redirect_pc(b_rpc), .ex_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_in();
    ws_valid = 1'b0;
    ws_ex    = 1'b0;
    ws_ertn  = 1'b0;
    has_int  = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    idle_in();
    ws_pc          = 32'd0;
    ws_ecode       = 6'd0;
    ws_esubcode    = 9'd0;
    csr_excp_pc    = 32'h1C008000;
    csr_ertn_pc    = 32'h1C000104;
    redirect_ready = 1'b1;
    step(3);
    chk("rst_allowin", a_allowin, 1);
    chk("rst_flush", a_flush, 0);
    chk("rst_wb_ex", a_wb_ex, 0);
    chk("rst_rv", a_rv, 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_cnt", a_cnt, 0);
    reset = 1'b0;
    step(1);

    // has_int with no instruction in WB
    has_int = 1'b1;
    #1;
    chk("noinst_cancel", a_cancel, 0);
    step(1);
    chk("noinst_flush", a_flush, 0);
    chk("noinst_allowin", a_allowin, 1);
    has_int = 1'b0;

    // exception, 2-cycle drain; ready already high
    ws_valid    = 1'b1;
    ws_ex       = 1'b1;
    ws_ecode    = 6'h0B;
    ws_esubcode = 9'h005;
    ws_pc       = 32'h1C000100;
    #1;
    chk("ex_cancel_T", a_cancel, 1);
    step(1);
    idle_in();
    chk("ex_wbex_T1", a_wb_ex, 1);
    chk("ex_pc_T1", a_pc, 32'h1C000100);
    chk("ex_ecode_T1", a_ecode, 6'h0B);
    chk("ex_esub_T1", a_esub, 9'h005);
    chk("ex_flush_T1", a_flush, 1);
    chk("ex_allowin_T1", a_allowin, 0);
    chk("ex_ertn_T1", a_ertn, 0);
    step(1);
    chk("ex_wbex_T2", a_wb_ex, 0);
    chk("ex_cnt_T2", a_cnt, 1);
    chk("ex_rv_T2", a_rv, 0);
    step(1);
    chk("ex_rv_T3", a_rv, 0);
    chk("ex_flush_T3", a_flush, 1);
    step(1);
    chk("ex_rv_T4", a_rv, 1);
    chk("ex_rpc_T4", a_rpc, 32'h1C008000);
    chk("ex_flush_T4", a_flush, 1);
    step(1);
    chk("ex_flush_T5", a_flush, 0);
    chk("ex_allowin_T5", a_allowin, 1);
    chk("ex_pc_hold", a_pc, 32'h1C000100);

    // ertn on the zero-drain instance
    ws_valid = 1'b1;
    ws_ertn  = 1'b1;
    ws_pc    = 32'h1C000300;
    #1;
    chk("ertn_cancel_T", b_cancel, 0);
    step(1);
    idle_in();
    chk("ertn_flush_T1", b_ertn, 1);
    chk("ertn_wbex_T1", b_wb_ex, 0);
    chk("ertn_pc_T1", b_pc, 32'h1C000300);
    step(1);
    chk("ertn_rv_T2", b_rv, 1);
    chk("ertn_rpc_T2", b_rpc, 32'h1C000104);
    chk("ertn_cnt", b_cnt, 1);
    chk("ertn_flushpulse_T2", b_ertn, 0);
    step(1);
    chk("ertn_idle_T3", b_allowin, 1);
    step(2);
    chk("ertn_dut0_idle", a_allowin, 1);
    chk("ertn_dut0_cnt", a_cnt, 1);

    // interrupt beats exception; redirect stalled 5 cycles
    ws_valid    = 1'b1;
    has_int     = 1'b1;
    ws_ex       = 1'b1;
    ws_ecode    = 6'h09;
    ws_esubcode = 9'h011;
    ws_pc       = 32'h1C000200;
    #1;
    chk("int_cancel_T", a_cancel, 1);
    step(1);
    idle_in();
    redirect_ready = 1'b0;
    chk("int_wbex_T1", a_wb_ex, 1);
    chk("int_ecode_T1", a_ecode, 6'h00);
    chk("int_esub_T1", a_esub, 9'h000);
    chk("int_pc_T1", a_pc, 32'h1C000200);
    step(3);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rv", a_rv, 1);
      chk("stall_flush", a_flush, 1);
      chk("stall_allowin", a_allowin, 0);
      step(1);
    end
    ws_valid = 1'b1;
    ws_ex    = 1'b1;
    #1;
    chk("stall_ignore_cancel", a_cancel, 0);
    redirect_ready = 1'b1;
    #1;
    chk("hs_rv_R", a_rv, 1);
    chk("hs_flush_R", a_flush, 1);
    step(1);
    idle_in();
    #1;
    chk("hs_flush_R1", a_flush, 0);
    chk("hs_allowin_R1", a_allowin, 1);
    chk("hs_rv_R1", a_rv, 0);
    chk("int_cnt", a_cnt, 2);
    step(2);

    // reset in DRAIN, then a normal exception
    ws_valid = 1'b1;
    ws_ex    = 1'b1;
    ws_ecode = 6'h0E;
    ws_pc    = 32'h1C000400;
    step(1);
    idle_in();
    step(1);
    chk("drain_flush", a_flush, 1);
    reset = 1'b1;
    #1;
    chk("rstd_flush", a_flush, 0);
    chk("rstd_allowin", a_allowin, 1);
    chk("rstd_rv", a_rv, 0);
    chk("rstd_wbex", a_wb_ex, 0);
    chk("rstd_pc", a_pc, 0);
    chk("rstd_cnt", a_cnt, 0);
    step(1);
    reset = 1'b0;
    step(1);
    chk("post_rst_wbex", a_wb_ex, 0);
    chk("post_rst_flush", a_flush, 0);
    ws_valid = 1'b1;
    ws_ex    = 1'b1;
    ws_ecode = 6'h0E;
    ws_pc    = 32'h1C000500;
    #1;
    chk("re_cancel", a_cancel, 1);
    step(1);
    idle_in();
    chk("re_wbex", a_wb_ex, 1);
    chk("re_pc", a_pc, 32'h1C000500);
    chk("re_ecode", a_ecode, 6'h0E);
    step(1);
    chk("re_cnt", a_cnt, 1);
    step(2);
    chk("re_rv", a_rv, 1);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/excp_ctrl.md
# excp_ctrl

Exception/interrupt commit sequencer in the write-back stage of the five-stage LoongArch pipeline. It arbitrates between pending interrupts, synchronous exceptions and `ertn` on the retiring instruction, and drives the one-cycle `wb_ex` / `ertn_flush` pulses into the CSR file. It then holds a pipeline-wide flush for a programmable drain period and issues a handshaked PC redirect to the fetch stage.

## Interface
- `FLUSH_CYCLES`, default 2: drain cycles between the commit pulse and the redirect request; legal range 0..15.
- `clk` input 1: clock.
- `reset` input 1: reset, asynchronous, active-high.
- `ws_valid` input 1: WB holds a retiring instruction.
- `ws_pc` input 32: PC of the WB instruction.
- `ws_ex` input 1: WB instruction carries a synchronous exception.
- `ws_ecode` input 6: ecode for `ws_ex`.
- `ws_esubcode` input 9: esubcode for `ws_ex`.
- `ws_ertn` input 1: WB instruction is `ertn`.
- `has_int` input 1: CSR interrupt-pending indication, already masked by LIE and IE.
- `csr_excp_pc` input 32: EENTRY value.
- `csr_ertn_pc` input 32: ERA value.
- `redirect_ready` input 1: fetch stage accepts the redirect.
- `ws_allowin` output 1: WB may accept a new instruction.
- `ws_cancel` output 1: suppress regfile/CSR side effects of the current WB instruction.
- `wb_ex` output 1: exception commit pulse to CSR.
- `wb_ecode` output 6: ecode to CSR.
- `wb_esubcode` output 9: esubcode to CSR.
- `wb_pc` output 32: faulting PC to CSR.
- `ertn_flush` output 1: `ertn` commit pulse to CSR.
- `flush` output 1: kill all younger pipeline stages.
- `redirect_valid` output 1: redirect request to fetch.
- `redirect_pc` output 32: redirect target.
- `ex_cnt` output 32: count of committed exceptions and interrupts.

## Operation
- FSM states: IDLE, COMMIT, DRAIN, REDIRECT.
- Event detection in IDLE only, when `ws_valid`=1. Priority:
  - `has_int` first: ecode 0x00, esubcode 0.
  - `ws_ex` second: uses `ws_ecode` / `ws_esubcode`.
  - `ws_ertn` third.
- `ws_cancel` is combinational: 1 when an exception or interrupt event is detected in IDLE; 0 for `ertn` and all other cases.
- IDLE to COMMIT on any event. The block registers the event kind (ex or ertn), `wb_pc`=`ws_pc`, `wb_ecode` and `wb_esubcode`.
- COMMIT lasts exactly 1 cycle.
  - Asserts `wb_ex`=1 for ex/int, or `ertn_flush`=1 for ertn.
  - `ex_cnt` increments on ex/int only, wrapping mod 2^32.
  - Next state is DRAIN with a 4-bit counter loaded to `FLUSH_CYCLES`-1. If `FLUSH_CYCLES`=0, next state is REDIRECT.
- DRAIN decrements the counter each cycle and moves to REDIRECT when the counter is 0.
- REDIRECT:
  - `redirect_valid`=1.
  - `redirect_pc` is `csr_ertn_pc` for ertn, else `csr_excp_pc`, sampled combinationally and stable while waiting.
  - Holds until `redirect_ready`=1, then returns to IDLE.
- `flush`=1 in COMMIT, DRAIN and REDIRECT, including the handshake cycle.
- `ws_allowin`=1 only in IDLE. `ws_valid` outside IDLE is ignored: no event, no commit.
- `wb_ecode`, `wb_esubcode` and `wb_pc` hold their last registered value outside COMMIT.

## Timing
- Reset values: state IDLE; `wb_ex`, `ertn_flush`, `flush`, `redirect_valid` = 0; `wb_pc`, `wb_ecode`, `wb_esubcode`, `ex_cnt` = 0; `ws_allowin`=1.
- Event seen at cycle T:
  - `ws_cancel`=1 at T.
  - `wb_ex` / `ertn_flush` = 1 at T+1 only.
  - `flush` rises at T+1.
  - `redirect_valid` rises at T+2+`FLUSH_CYCLES`.
- Redirect accepted at cycle R (`redirect_valid` & `redirect_ready`): `flush`=0 and `ws_allowin`=1 from R+1.
- `redirect_ready` asserted early (before REDIRECT) has no effect.
- `has_int` and `ws_ex` on the same instruction: interrupt wins, ecode 0x00.
- `ws_ex` and `ws_ertn` together: exception wins, `ertn_flush` stays 0.
- `has_int` with `ws_valid`=0: no action until an instruction reaches WB.
- `reset` asserted in any state: immediate return to IDLE with all reset values; no partial pulse after release.

## Test plan
- `ws_valid`=1, `ws_ex`=1, ecode 0x0B, `ws_pc`=0x1C000100, `FLUSH_CYCLES`=2, `csr_excp_pc`=0x1C008000, `redirect_ready`=1:
  - `ws_cancel` at T.
  - `wb_ex` pulse at T+1 with `wb_pc`=0x1C000100, ecode 0x0B.
  - `redirect_valid` at T+4 with `redirect_pc`=0x1C008000.
  - `ex_cnt`=1.
- `ws_ertn`=1, `csr_ertn_pc`=0x1C000104, `FLUSH_CYCLES`=0: `ertn_flush` at T+1, `wb_ex`=0, `redirect_pc`=0x1C000104 at T+2, `ex_cnt` unchanged.
- `has_int`=1 together with `ws_ex`=1 (ecode 0x09): committed ecode 0x00.
- `redirect_ready` held low 5 cycles in REDIRECT: `redirect_valid` and `flush` stay 1 and `ws_allowin` stays 0 throughout; return to IDLE the cycle after `ready` rises.
- `reset` asserted in DRAIN: all outputs at reset values immediately; the next `ws_ex` is processed normally with `ex_cnt`=1.
